// File: rtl/seq_timing_gen.sv
// Sequence counter and one-hot timing generator feeding the control unit, with run/halt/step control.
// T follows registered SC in the same cycle; CLRSEQ/INCSEQ take effect at the next edge; no backpressure.
module seq_timing_gen #(
  parameter int SC_WIDTH  = 3,
  parameter int T_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 HALT,
  input  logic                 STEP_MODE,
  input  logic                 STEP,
  input  logic                 CLRSEQ,
  input  logic                 INCSEQ,
  output logic [T_WIDTH-1:0]   T,
  output logic [SC_WIDTH-1:0]  SC,
  output logic                 RUN,
  output logic                 OVERRUN,
  output logic [CNT_WIDTH-1:0] INSTR_CNT
);

  localparam logic [1:0] ST_HALTED    = 2'd0;
  localparam logic [1:0] ST_RUNNING   = 2'd1;
  localparam logic [1:0] ST_STEP_HOLD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SC_WIDTH-1:0]  sc_q, sc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 halt_pend_q, halt_pend_d;
  logic                 step_q, step_d;
  logic                 run_q, run_d;
  logic                 step_rise;

  assign step_rise = STEP && !step_q;
  assign step_d    = STEP;

  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      ST_RUNNING: begin
        if (CLRSEQ) begin
          sc_d  = '0;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (halt_pend_q || HALT) begin
            state_d     = ST_HALTED;
            halt_pend_d = 1'b0;
          end else if (STEP_MODE) begin
            state_d = ST_STEP_HOLD;
          end
        end else begin
          if (INCSEQ) begin
            sc_d = sc_q + SC_WIDTH'(1);
            // Running off the end of the timing bus means the control unit missed its CLRSEQ.
            if (sc_q == SC_WIDTH'(T_WIDTH - 1)) overrun_d = 1'b1;
          end
          if (HALT) halt_pend_d = 1'b1;
        end
      end
      ST_STEP_HOLD: begin
        sc_d = '0;
        if (HALT) begin
          state_d     = ST_HALTED;
          halt_pend_d = 1'b0;
        end else if (step_rise || !STEP_MODE) begin
          state_d = ST_RUNNING;
        end
      end
      default: begin
        sc_d        = '0;
        halt_pend_d = 1'b0;
        state_d     = ST_HALTED;
        if (START && !HALT) begin
          state_d   = ST_RUNNING;
          overrun_d = 1'b0;
        end
      end
    endcase
    run_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_HALTED;
      sc_q        <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      halt_pend_q <= 1'b0;
      step_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      halt_pend_q <= halt_pend_d;
      step_q      <= step_d;
      run_q       <= run_d;
    end
  end

  always_comb begin
    T = '0;
    if (state_q == ST_RUNNING) T[sc_q] = 1'b1;
  end

  assign SC        = sc_q;
  assign RUN       = run_q;
  assign OVERRUN   = overrun_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_seq_timing_gen.sv
// Directed bench for seq_timing_gen; expected outputs queued per driven cycle and checked after the edge.
module tb_seq_timing_gen;

  logic        CLK, RST_N;
  logic        START, HALT, STEP_MODE, STEP, CLRSEQ, INCSEQ;
  logic [7:0]  T;
  logic [2:0]  SC;
  logic        RUN, OVERRUN;
  logic [15:0] INSTR_CNT;

  int total  = 0;
  int passed = 0;

  localparam logic [5:0] I_NO = 6'b000000;
  localparam logic [5:0] I_ST = 6'b100000;
  localparam logic [5:0] I_HL = 6'b010000;
  localparam logic [5:0] I_SM = 6'b001000;
  localparam logic [5:0] I_SP = 6'b000100;
  localparam logic [5:0] I_CL = 6'b000010;
  localparam logic [5:0] I_IN = 6'b000001;

  typedef struct {
    string       tag;
    logic [7:0]  t;
    logic        run;
    logic [2:0]  sc;
    logic        ovr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  seq_timing_gen dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .HALT(HALT), .STEP_MODE(STEP_MODE),
    .STEP(STEP), .CLRSEQ(CLRSEQ), .INCSEQ(INCSEQ), .T(T), .SC(SC), .RUN(RUN),
    .OVERRUN(OVERRUN), .INSTR_CNT(INSTR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.tag, ".T"},   32'(T),         32'(e.t));
    chk({e.tag, ".RUN"}, 32'(RUN),       32'(e.run));
    chk({e.tag, ".SC"},  32'(SC),        32'(e.sc));
    chk({e.tag, ".OVR"}, 32'(OVERRUN),   32'(e.ovr));
    chk({e.tag, ".CNT"}, 32'(INSTR_CNT), 32'(e.cnt));
  endtask

  task automatic cyc(input logic [5:0] iv, input string tag, input logic [7:0] et,
                     input logic er, input logic [2:0] es, input logic eo, input logic [15:0] ec);
    exp_t e;
    @(negedge CLK);
    {START, HALT, STEP_MODE, STEP, CLRSEQ, INCSEQ} = iv;
    e.tag = tag; e.t = et; e.run = er; e.sc = es; e.ovr = eo; e.cnt = ec;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      check_outputs(sb.pop_front());
    end
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e.tag = tag; e.t = 8'h00; e.run = 1'b0; e.sc = 3'd0; e.ovr = 1'b0; e.cnt = 16'h0000;
    check_outputs(e);
  endtask

  initial begin
    RST_N = 1'b0;
    {START, HALT, STEP_MODE, STEP, CLRSEQ, INCSEQ} = I_NO;
    #3;
    check_reset("rst");
    @(negedge CLK);
    RST_N = 1'b1;

    // basic start, increment and clear
    cyc(I_NO, "idle",   8'h00, 0, 3'd0, 0, 16'd0);
    cyc(I_ST, "start",  8'h01, 1, 3'd0, 0, 16'd0);
    cyc(I_IN, "inc1",   8'h02, 1, 3'd1, 0, 16'd0);
    cyc(I_IN, "inc2",   8'h04, 1, 3'd2, 0, 16'd0);
    cyc(I_IN, "inc3",   8'h08, 1, 3'd3, 0, 16'd0);
    cyc(I_CL, "clr1",   8'h01, 1, 3'd0, 0, 16'd1);

    // halt at instruction boundary
    cyc(I_IN, "h_inc1", 8'h02, 1, 3'd1, 0, 16'd1);
    cyc(I_IN, "h_inc2", 8'h04, 1, 3'd2, 0, 16'd1);
    cyc(I_HL, "h_req",  8'h04, 1, 3'd2, 0, 16'd1);
    cyc(I_IN, "h_inc3", 8'h08, 1, 3'd3, 0, 16'd1);
    cyc(I_IN, "h_inc4", 8'h10, 1, 3'd4, 0, 16'd1);
    cyc(I_CL, "h_clr",  8'h00, 0, 3'd0, 0, 16'd2);
    cyc(I_IN, "h_ign1", 8'h00, 0, 3'd0, 0, 16'd2);
    cyc(I_CL, "h_ign2", 8'h00, 0, 3'd0, 0, 16'd2);

    // single-step with STEP held high
    cyc(I_ST,                      "s_start", 8'h01, 1, 3'd0, 0, 16'd2);
    cyc(I_SM | I_IN,               "s_inc",   8'h02, 1, 3'd1, 0, 16'd2);
    cyc(I_SM | I_CL,               "s_hold",  8'h00, 0, 3'd0, 0, 16'd3);
    cyc(I_SM | I_SP,               "s_step1", 8'h01, 1, 3'd0, 0, 16'd3);
    cyc(I_SM | I_SP | I_IN,        "s_step2", 8'h02, 1, 3'd1, 0, 16'd3);
    cyc(I_SM | I_SP | I_CL,        "s_step3", 8'h00, 0, 3'd0, 0, 16'd4);
    cyc(I_SM | I_SP,               "s_step4", 8'h00, 0, 3'd0, 0, 16'd4);
    cyc(I_SM | I_SP,               "s_step5", 8'h00, 0, 3'd0, 0, 16'd4);
    cyc(I_SM,                      "s_low",   8'h00, 0, 3'd0, 0, 16'd4);
    cyc(I_NO,                      "s_free",  8'h01, 1, 3'd0, 0, 16'd4);
    cyc(I_IN,                      "f_inc",   8'h02, 1, 3'd1, 0, 16'd4);
    cyc(I_CL,                      "f_clr",   8'h01, 1, 3'd0, 0, 16'd5);

    // eight increments wrap SC and set the sticky overrun
    for (int i = 1; i < 8; i++) begin
      logic [7:0] one_hot;
      one_hot = 8'h01 << i;
      cyc(I_IN, $sformatf("walk%0d", i), one_hot, 1, 3'(i), 0, 16'd5);
    end
    cyc(I_IN,        "wrap",     8'h01, 1, 3'd0, 1, 16'd5);
    cyc(I_CL,        "o_clr",    8'h01, 1, 3'd0, 1, 16'd6);
    cyc(I_HL,        "o_hreq",   8'h01, 1, 3'd0, 1, 16'd6);
    cyc(I_CL,        "o_halt",   8'h00, 0, 3'd0, 1, 16'd7);
    cyc(I_ST | I_HL, "st_and_h", 8'h00, 0, 3'd0, 1, 16'd7);
    cyc(I_ST,        "o_start",  8'h01, 1, 3'd0, 0, 16'd7);

    // CLRSEQ beats INCSEQ
    cyc(I_IN,        "p_inc1",   8'h02, 1, 3'd1, 0, 16'd7);
    cyc(I_IN,        "p_inc2",   8'h04, 1, 3'd2, 0, 16'd7);
    cyc(I_IN,        "p_inc3",   8'h08, 1, 3'd3, 0, 16'd7);
    cyc(I_CL | I_IN, "p_both",   8'h01, 1, 3'd0, 0, 16'd8);

    // asynchronous reset in the middle of an instruction
    #2;
    RST_N = 1'b0;
    #1;
    check_reset("rst_a");
    @(negedge CLK);
    RST_N = 1'b1;
    {START, HALT, STEP_MODE, STEP, CLRSEQ, INCSEQ} = I_NO;
    cyc(I_ST, "r_start", 8'h01, 1, 3'd0, 0, 16'd0);
    for (int i = 1; i <= 5; i++)
      cyc(I_CL, $sformatf("r_clr%0d", i), 8'h01, 1, 3'd0, 0, 16'(i));
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] one_hot;
      one_hot = 8'h01 << i;
      cyc(I_IN, $sformatf("r_inc%0d", i), one_hot, 1, 3'(i), 0, 16'd5);
    end
    #2;
    RST_N = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge CLK);
    RST_N = 1'b1;
    {START, HALT, STEP_MODE, STEP, CLRSEQ, INCSEQ} = I_NO;
    cyc(I_NO, "post_rst", 8'h00, 0, 3'd0, 0, 16'd0);

    // retired-instruction counter wraps modulo 2**16
    cyc(I_ST, "c_start", 8'h01, 1, 3'd0, 0, 16'd0);
    @(negedge CLK);
    {START, HALT, STEP_MODE, STEP, CLRSEQ, INCSEQ} = I_CL;
    repeat (65534) @(posedge CLK);
    cyc(I_CL, "c_max",  8'h01, 1, 3'd0, 0, 16'hFFFF);
    cyc(I_CL, "c_wrap", 8'h01, 1, 3'd0, 0, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_timing_gen.md
Name: seq_timing_gen

Overview:
- Sequence counter and timing generator directly upstream of the processor control unit.
- Holds the 3-bit sequence counter (SC) and decodes it into the one-hot timing bus T[7:0] that the control unit consumes.
- Consumes the control unit's CLRSEQ/INCSEQ strobes.
- Adds a run/halt flip-flop, instruction-boundary halt, single-step mode, overrun detection and a retired-instruction counter.

Parameters:
SC_WIDTH, 3, sequence counter width
T_WIDTH, 8, timing bus width; must equal 2**SC_WIDTH
CNT_WIDTH, 16, retired-instruction counter width

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  leave HALTED and begin execution
HALT  input  1  request halt at next instruction boundary
STEP_MODE  input  1  level; 1 = stop after each instruction
STEP  input  1  advance one instruction while in STEP_HOLD; rising-edge detected internally
CLRSEQ  input  1  from control unit: clear SC (instruction end)
INCSEQ  input  1  from control unit: increment SC
T  output  T_WIDTH  one-hot timing signals to control unit
SC  output  SC_WIDTH  current sequence count
RUN  output  1  1 while in RUNNING
OVERRUN  output  1  sticky: SC wrapped without CLRSEQ
INSTR_CNT  output  CNT_WIDTH  instructions retired

Behaviour:
- Reset (RST_N=0, asynchronous, also mid-instruction):
  - state=HALTED; SC=0; T=0; RUN=0; OVERRUN=0; INSTR_CNT=0.
  - Halt-pending flag and STEP edge-detect register cleared.
- T encoding: T = (state==RUNNING) ? (1<<SC) : 0. T is combinational from registered state/SC, so T0 appears in the same cycle RUNNING is entered. Exactly one bit is set while RUNNING, none otherwise.
- States: HALTED, RUNNING, STEP_HOLD.
- HALTED:
  - START=1 and HALT=0 -> RUNNING at the next edge; SC=0; OVERRUN cleared.
  - START and HALT both 1 -> stay HALTED.
  - CLRSEQ and INCSEQ are ignored.
- RUNNING, per edge:
  - CLRSEQ=1 (has priority over INCSEQ): SC<=0; INSTR_CNT<=INSTR_CNT+1, wrapping modulo 2**CNT_WIDTH. Next state:
    - HALTED if halt pending or HALT=1 this cycle; clear pending.
    - else STEP_HOLD if STEP_MODE=1.
    - else remain RUNNING.
  - INCSEQ=1 only: SC<=SC+1. If SC==T_WIDTH-1, SC wraps to 0, OVERRUN<=1 (sticky), and INSTR_CNT is unchanged.
  - Neither asserted: SC holds.
  - HALT=1 without CLRSEQ: set halt pending; execution continues until the next CLRSEQ. The current instruction is never aborted.
- STEP_HOLD:
  - T=0, SC=0, RUN=0.
  - HALT=1 -> HALTED at the next edge (takes priority).
  - Else a STEP rising edge (STEP=1 and registered STEP=0) -> RUNNING for one instruction.
  - Else STEP_MODE=0 -> RUNNING (free run).
  - CLRSEQ and INCSEQ are ignored.
- STEP level held high produces exactly one instruction. The edge register samples STEP in every state.
- OVERRUN clears only on reset or on the HALTED->RUNNING START transition.
- All outputs are registered except T, which is a pure decode of registered values.
- Latency:
  - START edge -> T0 in the following cycle.
  - INCSEQ in the cycle with Tk -> Tk+1 in the next cycle.
  - CLRSEQ -> T0 in the next cycle if still RUNNING.

Test Plan:
- Reset release with START pulse at cycle 2 -> T=8'h01 and RUN=1 from cycle 3; INCSEQ held 3 cycles -> T=02,04,08; CLRSEQ -> T=01, INSTR_CNT=1.
- HALT pulse while T=8'h04, then INCSEQ, INCSEQ, CLRSEQ -> T=08, 10, then RUN=0, T=00, SC=0, INSTR_CNT incremented once; subsequent INCSEQ has no effect.
- STEP_MODE=1, run instruction to CLRSEQ -> STEP_HOLD, T=00. STEP held high 5 cycles -> exactly one instruction runs (T=01, then back to 00 after its CLRSEQ). Drop STEP_MODE -> free run resumes.
- 8 consecutive INCSEQ from T0 -> T walks 01..80 then 01; OVERRUN=1 and stays 1 after CLRSEQ; INSTR_CNT unchanged by the wrap; cleared by HALT then START.
- CLRSEQ and INCSEQ together at T=8'h08 -> T=01 next cycle, INSTR_CNT+1. START and HALT together in HALTED -> stays HALTED.
- RST_N asserted asynchronously mid-cycle at T=8'h10 with INSTR_CNT=0x0005 -> T=00, SC=0, RUN=0, INSTR_CNT=0 immediately, without waiting for a clock edge; INSTR_CNT at 0xFFFF plus CLRSEQ -> 0x0000.
